// File: rtl/status_vector_sched.sv
// status_vector_sched
//   Shift-queue scheduler shared by N_REQ push requesters and one pull consumer.
//   The head of the queue is always entry [0]. An accepted pull shifts every
//   entry down by one. A push is written just above the last valid entry.
//   Push arbitration is round-robin, starting at a registered pointer.
//
//   Optional build macro STATUS_VECTOR_SCHED_STATS_EN adds two outputs:
//     hwm_o      : high-water mark of count_o since reset or flush
//     drop_cnt_o : saturating count of cycles in which a push was blocked by full
//
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_valid_i    per-requester push request
//   req_value_i    push data, requester k at [k*WIDTH +: WIDTH]
//   req_ready_o    one-hot grant
//   pull_i         consumer pulls the head entry
//   flush_i        discard all entries (has priority over push and pull)
//   head_valid_o   entry [0] is valid
//   head_value_o   entry [0] value (0 when empty)
//   count_o        occupancy
//   full_o         count_o == DEPTH
//   empty_o        count_o == 0

// One queue slot. A load (push) takes priority over a shift (pull).
module status_vector_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] shift_val,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk_i) begin
    if (rst_i)      q <= '0;
    else if (load)  q <= load_val;
    else if (shift) q <= shift_val;
  end
endmodule

module status_vector_sched #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int N_REQ = 4,
  localparam int CW = $clog2(DEPTH+1),
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*WIDTH-1:0] req_value_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic                   pull_i,
  input  logic                   flush_i,
  output logic                   head_valid_o,
  output logic [WIDTH-1:0]       head_value_o,
  output logic [CW-1:0]          count_o,
  output logic                   full_o,
`ifdef STATUS_VECTOR_SCHED_STATS_EN
  output logic [CW-1:0]          hwm_o,
  output logic [15:0]            drop_cnt_o,
`endif
  output logic                   empty_o
);
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0]            vld, vld_nxt;
  logic [CW-1:0]               cnt, cnt_nxt, wr_idx;
  logic [PW-1:0]               ptr, ptr_nxt;
  logic [PW-1:0]               gnt_idx;
  logic                        gnt_any, push, eff_pull, push_ok;
  logic [WIDTH-1:0]            push_val;
  int                          idx;

  assign empty_o  = (cnt == '0);
  assign full_o   = (cnt == CW'(DEPTH));
  assign count_o  = cnt;
  assign eff_pull = pull_i & ~empty_o & ~flush_i;
  // A simultaneous pull frees a slot, so a full queue can still accept a push.
  assign push_ok  = ~flush_i & (~full_o | eff_pull);

  // Round-robin: the first asserted request at or after ptr wins.
  always_comb begin
    gnt_any     = 1'b0;
    gnt_idx     = '0;
    req_ready_o = '0;
    idx         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_any && req_valid_i[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (gnt_any && push_ok) req_ready_o[gnt_idx] = 1'b1;
  end

  assign push     = gnt_any & push_ok;
  assign push_val = req_value_i[gnt_idx*WIDTH +: WIDTH];
  // After a shift the first free slot is one lower.
  assign wr_idx   = eff_pull ? cnt - CW'(1) : cnt;
  assign ptr_nxt  = (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + PW'(1);

  always_comb begin
    cnt_nxt = cnt;
    if (flush_i)                cnt_nxt = '0;
    else if (push && !eff_pull) cnt_nxt = cnt + CW'(1);
    else if (eff_pull && !push) cnt_nxt = cnt - CW'(1);
    // The valid mask is a thermometer of the occupancy.
    vld_nxt = '0;
    for (int i = 0; i < DEPTH; i++) vld_nxt[i] = (CW'(i) < cnt_nxt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      vld <= '0;
      ptr <= '0;
    end else begin
      cnt <= cnt_nxt;
      vld <= vld_nxt;
      if (push) ptr <= ptr_nxt;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [WIDTH-1:0] shift_val;
    if (g == DEPTH-1) begin : g_top
      assign shift_val = '0;
    end else begin : g_mid
      assign shift_val = data[g+1];
    end
    status_vector_entry #(.WIDTH(WIDTH)) u_ent (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load      (push && (wr_idx == CW'(g))),
      .shift     (eff_pull),
      .load_val  (push_val),
      .shift_val (shift_val),
      .q         (data[g])
    );
  end

  assign head_valid_o = vld[0];
  assign head_value_o = vld[0] ? data[0] : '0;

`ifdef STATUS_VECTOR_SCHED_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      hwm_o      <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (cnt > hwm_o) hwm_o <= cnt;
      if (|req_valid_i && full_o && !eff_pull && drop_cnt_o != 16'hFFFF)
        drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_status_vector_sched.sv
module tb_status_vector_sched;
  localparam int WIDTH = 8, DEPTH = 8, N_REQ = 4, CW = 4;

  logic                   clk_i = 0, rst_i = 1;
  logic [N_REQ-1:0]       req_valid_i = '0;
  logic [N_REQ*WIDTH-1:0] req_value_i = '0;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   pull_i = 0, flush_i = 0;
  logic                   head_valid_o, full_o, empty_o;
  logic [WIDTH-1:0]       head_value_o;
  logic [CW-1:0]          count_o;
`ifdef STATUS_VECTOR_SCHED_STATS_EN
  logic [CW-1:0]          hwm_o;
  logic [15:0]            drop_cnt_o;
`endif

  int checks = 0, errors = 0;

  status_vector_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_value_i(req_value_i),
    .req_ready_o(req_ready_o), .pull_i(pull_i), .flush_i(flush_i),
    .head_valid_o(head_valid_o), .head_value_o(head_value_o), .count_o(count_o),
    .full_o(full_o),
`ifdef STATUS_VECTOR_SCHED_STATS_EN
    .hwm_o(hwm_o), .drop_cnt_o(drop_cnt_o),
`endif
    .empty_o(empty_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic push1(input logic [WIDTH-1:0] v);
    req_valid_i = 4'b0001; req_value_i = {24'h0, v};
    step();
    req_valid_i = '0;
  endtask

  initial begin
    // Reset state
    step(); step();
    rst_i = 0; #1;
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_hvalid", head_valid_o, 0);
    chk("rst_hvalue", head_value_o, 0);

    // Single push on empty queue
    req_valid_i = 4'b0001; req_value_i = 32'h0000_0011; #1;
    chk("t1_ready", req_ready_o, 4'b0001);
    step(); req_valid_i = '0;
    chk("t1_hvalid", head_valid_o, 1);
    chk("t1_hvalue", head_value_o, 8'h11);
    chk("t1_count", count_o, 1);

    // Reset with pending request and pull: everything clears
    rst_i = 1; req_valid_i = 4'b1111; pull_i = 1;
    step();
    rst_i = 0; req_valid_i = '0; pull_i = 0; #1;
    chk("rst2_count", count_o, 0);
    chk("rst2_hvalid", head_valid_o, 0);

    // Round robin with all requesters asserted, pointer at 0 after reset
    req_valid_i = 4'b1111; req_value_i = 32'hA3A2_A1A0;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("rr_ready%0d", k), req_ready_o, 4'b0001 << k);
      step();
    end
    req_valid_i = '0;
    chk("rr_count", count_o, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_head%0d", k), head_value_o, 8'hA0 + k);
      pull_i = 1; step(); pull_i = 0;
    end
    chk("rr_empty", empty_o, 1);

    // Fill to full
    for (int k = 0; k < 8; k++) push1(8'h30 + k);
    chk("fill_full", full_o, 1);
    chk("fill_count", count_o, 8);
    // Full, no pull: blocked
    req_valid_i = 4'b0001; req_value_i = 32'h40; #1;
    chk("full_block_ready", req_ready_o, 4'b0000);
    step();
    chk("full_block_count", count_o, 8);
    // Full with pull: push accepted at the top
    pull_i = 1; #1;
    chk("full_pull_ready", req_ready_o, 4'b0001);
    step(); pull_i = 0; req_valid_i = '0;
    chk("full_pull_count", count_o, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d", k), head_value_o, (k == 7) ? 8'h40 : 8'h31 + k);
      pull_i = 1; step(); pull_i = 0;
    end
    chk("drain_empty", empty_o, 1);
    // Pull on empty is ignored
    pull_i = 1; step(); pull_i = 0;
    chk("pull_empty_count", count_o, 0);

    // Empty queue, pull with push
    pull_i = 1; req_valid_i = 4'b0001; req_value_i = 32'h5A; #1;
    chk("ep_ready", req_ready_o, 4'b0001);
    step(); pull_i = 0; req_valid_i = '0;
    chk("ep_count", count_o, 1);
    chk("ep_head", head_value_o, 8'h5A);

    // Flush at count 5 beats pull and push
    for (int k = 0; k < 4; k++) push1(8'h60 + k);
    chk("pre_flush_count", count_o, 5);
    flush_i = 1; pull_i = 1; req_valid_i = 4'b0100; req_value_i = 32'h0077_0000; #1;
    chk("flush_ready", req_ready_o, 4'b0000);
    step(); flush_i = 0; pull_i = 0; req_valid_i = '0;
    chk("flush_count", count_o, 0);
    chk("flush_empty", empty_o, 1);
    chk("flush_hvalue", head_value_o, 0);

`ifdef STATUS_VECTOR_SCHED_STATS_EN
    for (int k = 0; k < 6; k++) push1(8'h80 + k);
    pull_i = 1; step(); step(); pull_i = 0;
    chk("hwm_6", hwm_o, 6);
    flush_i = 1; step(); flush_i = 0;
    chk("hwm_flush", hwm_o, 0);
    for (int k = 0; k < 8; k++) push1(8'h90 + k);
    chk("drop_pre", drop_cnt_o, 0);
    req_valid_i = 4'b0010; step(); step(); step(); req_valid_i = '0;
    chk("drop_3", drop_cnt_o, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
